// File: rtl/pc_reg_unit.sv
// pc_reg_unit: program-counter state element for the IF stage of the RV32I core.
// Holds the current fetch PC, loads the next PC chosen by the upstream IF mux,
// and exposes PC+INCR, the previously held PC, a valid flag and a misalignment flag.
// Next-PC selection is not done here; this block is purely a register stage.

module pc_reg_unit #(
  parameter int unsigned           WIDTH        = 32,
  parameter logic [WIDTH-1:0]      RESET_VECTOR = 32'h6000_0000,
  parameter int unsigned           INCR         = 4
) (
  input  logic             clk,
  input  logic             rst,        // asynchronous, active-low
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_plus4,
  output logic [WIDTH-1:0] prev_out,
  output logic             valid,
  output logic             misaligned
);

  logic [WIDTH-1:0] pc_d,      pc_q;
  logic [WIDTH-1:0] prev_pc_d, prev_pc_q;
  logic             valid_d,   valid_q;

  // Next-state selection: a load captures the new PC and shifts the old one into prev.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    pc_d      = pc_q;
    prev_pc_d = prev_pc_q;
    valid_d   = valid_q;
    // The select is the only thing that gates `in`, so an X on `in` while
    // load is low never reaches the flops.
    if (load) begin
      pc_d      = in;
      prev_pc_d = pc_q;
      valid_d   = 1'b1;
    end
  end

  // State registers; reset forces the fetch address back to the reset vector at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= RESET_VECTOR;
      prev_pc_q <= RESET_VECTOR;
      valid_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so prev_pc_q samples the pre-edge pc_q
      // regardless of statement order.
      pc_q      <= pc_d;
      prev_pc_q <= prev_pc_d;
      valid_q   <= valid_d;
    end
  end

  // Derived outputs depend only on the held PC, so they track reset asynchronously too.
  assign out        = pc_q;
  assign prev_out   = prev_pc_q;
  assign valid      = valid_q;
  assign out_plus4  = pc_q + WIDTH'(INCR);   // wraps modulo 2^WIDTH, no carry out
  assign misaligned = |pc_q[1:0];

endmodule

// File: tb/tb_pc_reg_unit.sv
// tb_pc_reg_unit: directed bench for pc_reg_unit with a scoreboard queue of
// expected register states, compared after each edge or async event.

module tb_pc_reg_unit;

  typedef struct {
    string       tag;
    logic [31:0] out;
    logic [31:0] prev;
    logic        valid;
    logic [31:0] plus4;
    logic        mis;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        load;
  logic [31:0] in;
  logic [31:0] out;
  logic [31:0] out_plus4;
  logic [31:0] prev_out;
  logic        valid;
  logic        misaligned;

  int total = 0;
  int bad   = 0;

  exp_t sb[$];

  // Reference state of the PC register, kept independently of the DUT.
  logic [31:0] m_pc;
  logic [31:0] m_prev;
  logic        m_valid;

  localparam logic [31:0] RV = 32'h6000_0000;

  pc_reg_unit dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .in         (in),
    .out        (out),
    .out_plus4  (out_plus4),
    .prev_out   (prev_out),
    .valid      (valid),
    .misaligned (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = RV;
    m_prev  = RV;
    m_valid = 1'b0;
  endtask

  task automatic push_exp(input string tag);
    exp_t e;
    e.tag   = tag;
    e.out   = m_pc;
    e.prev  = m_prev;
    e.valid = m_valid;
    e.plus4 = m_pc + 32'd4;
    e.mis   = (m_pc[1:0] != 2'b00);
    sb.push_back(e);
  endtask

  task automatic check_front();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    cmp({e.tag, ".out"},        out,               e.out);
    cmp({e.tag, ".prev_out"},   prev_out,          e.prev);
    cmp({e.tag, ".valid"},      {31'd0, valid},      {31'd0, e.valid});
    cmp({e.tag, ".out_plus4"},  out_plus4,         e.plus4);
    cmp({e.tag, ".misaligned"}, {31'd0, misaligned}, {31'd0, e.mis});
  endtask

  // Drive one clock edge with the given load/in, predict, then compare after the edge.
  task automatic step(input logic ld, input logic [31:0] d, input string tag);
    @(negedge clk);
    load = ld;
    in   = d;
    if (rst && ld) begin
      m_prev  = m_pc;
      m_pc    = d;
      m_valid = 1'b1;
    end
    push_exp(tag);
    @(posedge clk);
    #1;
    check_front();
  endtask

  initial begin
    rst  = 1'b0;
    load = 1'b0;
    in   = '0;
    model_reset();

    // 1. Reset state, checked while held and after release.
    #12;
    push_exp("reset_held");
    check_front();
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 32'h0, "reset_release");

    // 2. First load, then hold with unrelated data on in.
    step(1'b1, 32'h6000_0004, "first_load");
    for (int i = 0; i < 3; i++) step(1'b0, 32'h1234_5678, $sformatf("hold%0d", i));

    // 3. Branch targets, aligned then misaligned.
    step(1'b1, 32'h6000_0100, "branch");
    step(1'b1, 32'h6000_0102, "misaligned_load");

    // 4. Wrap-around, then reloading the same value still counts as a load.
    step(1'b1, 32'hFFFF_FFFC, "wrap");
    step(1'b1, 32'hFFFF_FFFC, "same_value");

    // X on in while load is low must not disturb the register.
    step(1'b0, 32'hxxxx_xxxx, "x_in_hold");

    // 5. Async reset mid-operation, then load held during reset is ignored.
    step(1'b1, 32'h6000_0200, "pre_reset_load");
    @(negedge clk);
    load = 1'b0;
    #2;
    rst = 1'b0;
    model_reset();
    push_exp("async_reset");
    #1;
    check_front();
    step(1'b1, 32'hDEAD_BEEC, "load_in_reset");
    @(negedge clk);
    load = 1'b0;
    rst  = 1'b1;

    // 6. Back-to-back: feed out_plus4 back into in for four edges.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      load = 1'b1;
      in   = out_plus4;
      m_prev  = m_pc;
      m_pc    = m_pc + 32'd4;
      m_valid = 1'b1;
      push_exp($sformatf("b2b%0d", i));
      @(posedge clk);
      #1;
      check_front();
    end
    cmp("b2b_final_out", out, 32'h6000_0010);

    @(negedge clk);
    load = 1'b0;
    cmp("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
